// File: rtl/acs_array_pkg.sv
// Shared defaults and helpers for the add-compare-select array of a
// rate-1/2 Viterbi decoder.
package acs_array_pkg;

    localparam int DEF_K         = 3;
    localparam int DEF_G0        = 'o7;
    localparam int DEF_G1        = 'o5;
    localparam int DEF_BM_W      = 3;
    localparam int DEF_PM_W      = 5;
    localparam int DEF_INIT_BIAS = 8;

    function automatic logic parity(input logic [31:0] v);
        return ^v;
    endfunction

    // Encoder output {c0,c1} when leaving `state` with input bit `u`.
    function automatic logic [1:0] branch_symbol(input int k, input int g0, input int g1,
                                                 input int state, input int u);
        logic [31:0] mask;
        logic [31:0] r;
        mask = (32'd1 << k) - 32'd1;
        r    = ((32'(state) << 1) | (32'(u) & 32'd1)) & mask;
        return {parity(r & 32'(g0)), parity(r & 32'(g1))};
    endfunction

endpackage

// File: rtl/acs_cell.sv
// One trellis node: two saturating adds, compare, select and the survivor
// decision bit (ties resolve to the p0 predecessor).
module acs_cell
    import acs_array_pkg::*;
#(
    parameter int BM_W = DEF_BM_W,
    parameter int PM_W = DEF_PM_W
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [BM_W-1:0] bm0,
    input  logic [BM_W-1:0] bm1,
    output logic [PM_W-1:0] pm_new,
    output logic            dec
);

    localparam logic [PM_W-1:0] SAT = '1;

    logic [PM_W:0]   sum0;
    logic [PM_W:0]   sum1;
    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;

    assign sum0  = {1'b0, pm0} + (PM_W+1)'(bm0);
    assign sum1  = {1'b0, pm1} + (PM_W+1)'(bm1);
    assign cand0 = sum0[PM_W] ? SAT : sum0[PM_W-1:0];
    assign cand1 = sum1[PM_W] ? SAT : sum1[PM_W-1:0];

    assign dec    = (cand1 < cand0);
    assign pm_new = dec ? cand1 : cand0;

endmodule

// File: rtl/acs_array.sv
// Fully parallel ACS array: one trellis step per accepted cycle, with
// MSB normalisation, best-state search and a valid/ready decision output.
module acs_array
    import acs_array_pkg::*;
#(
    parameter int K         = DEF_K,
    parameter int G0        = DEF_G0,
    parameter int G1        = DEF_G1,
    parameter int BM_W      = DEF_BM_W,
    parameter int PM_W      = DEF_PM_W,
    parameter int INIT_BIAS = DEF_INIT_BIAS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      frame_start,
    input  logic [K-2:0]              start_state,
    input  logic [4*BM_W-1:0]         bm_in,
    output logic                      dec_valid,
    input  logic                      dec_ready,
    output logic [(1<<(K-1))-1:0]     dec_out,
    output logic [K-2:0]              best_state,
    output logic [PM_W-1:0]           best_metric,
    output logic                      norm_flag,
    output logic [15:0]               step_cnt
);

    localparam int NUM_STATES = 1 << (K-1);
    localparam int SW         = K - 1;
    localparam logic [PM_W-1:0] BIAS = PM_W'(INIT_BIAS);

    logic [NUM_STATES-1:0][PM_W-1:0] pm_reg;
    logic [NUM_STATES-1:0][PM_W-1:0] pm_old;
    logic [NUM_STATES-1:0][PM_W-1:0] pm_new;
    logic [NUM_STATES-1:0][PM_W-1:0] pm_store;
    logic [NUM_STATES-1:0]           dec_next;
    logic [NUM_STATES-1:0]           msb;
    logic                            norm_next;
    logic [SW-1:0]                   best_state_next;
    logic [PM_W-1:0]                 best_metric_next;
    logic                            step;

    assign in_ready  = !dec_valid || dec_ready;
    assign step      = in_valid && in_ready;
    assign norm_next = &msb;

    generate
        for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_state
            localparam int P0 = gi >> 1;
            localparam int P1 = P0 + NUM_STATES/2;
            localparam int U  = gi & 1;
            localparam int S0 = int'(branch_symbol(K, G0, G1, P0, U));
            localparam int S1 = int'(branch_symbol(K, G0, G1, P1, U));

            // A frame start replaces the stored metrics with the seeded ones.
            assign pm_old[gi] = frame_start ? ((start_state == SW'(gi)) ? '0 : BIAS)
                                            : pm_reg[gi];

            acs_cell #(
                .BM_W (BM_W),
                .PM_W (PM_W)
            ) u_cell (
                .pm0    (pm_old[P0]),
                .pm1    (pm_old[P1]),
                .bm0    (bm_in[S0*BM_W +: BM_W]),
                .bm1    (bm_in[S1*BM_W +: BM_W]),
                .pm_new (pm_new[gi]),
                .dec    (dec_next[gi])
            );

            assign msb[gi]      = pm_new[gi][PM_W-1];
            assign pm_store[gi] = {pm_new[gi][PM_W-1] & ~norm_next, pm_new[gi][PM_W-2:0]};
        end
    endgenerate

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        best_state_next  = '0;
        best_metric_next = pm_store[0];
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm_store[i] < best_metric_next) begin
                best_metric_next = pm_store[i];
                best_state_next  = SW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_valid   <= 1'b0;
            dec_out     <= '0;
            best_state  <= '0;
            best_metric <= '0;
            norm_flag   <= 1'b0;
            step_cnt    <= '0;
            for (int i = 0; i < NUM_STATES; i++) begin
                pm_reg[i] <= (i == 0) ? '0 : BIAS;
            end
        end else if (step) begin
            dec_valid   <= 1'b1;
            dec_out     <= dec_next;
            best_state  <= best_state_next;
            best_metric <= best_metric_next;
            norm_flag   <= norm_next;
            step_cnt    <= frame_start ? 16'd1 : step_cnt + 16'd1;
            pm_reg      <= pm_store;
        end else if (dec_ready) begin
            dec_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acs_array.sv
// Directed-vector bench for acs_array at K=3, G0=7, G1=5, BM_W=3, PM_W=5,
// INIT_BIAS=8, with hand-computed expected metrics and decisions.
module tb_acs_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        frame_start;
    logic [1:0]  start_state;
    logic [11:0] bm_in;
    logic        dec_valid;
    logic        dec_ready;
    logic [3:0]  dec_out;
    logic [1:0]  best_state;
    logic [4:0]  best_metric;
    logic        norm_flag;
    logic [15:0] step_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    acs_array dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .frame_start (frame_start),
        .start_state (start_state),
        .bm_in       (bm_in),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_out     (dec_out),
        .best_state  (best_state),
        .best_metric (best_metric),
        .norm_flag   (norm_flag),
        .step_cnt    (step_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_pm(input string tag, input int e0, input int e1, input int e2, input int e3);
        check_val({tag, "_pm0"}, 32'(dut.pm_reg[0]), 32'(e0));
        check_val({tag, "_pm1"}, 32'(dut.pm_reg[1]), 32'(e1));
        check_val({tag, "_pm2"}, 32'(dut.pm_reg[2]), 32'(e2));
        check_val({tag, "_pm3"}, 32'(dut.pm_reg[3]), 32'(e3));
    endtask

    task automatic check_out(input string tag, input int e_dec, input int e_bs,
                             input int e_bm, input int e_norm, input int e_cnt);
        check_val({tag, "_valid"}, 32'(dec_valid), 32'd1);
        check_val({tag, "_dec"},   32'(dec_out), 32'(e_dec));
        check_val({tag, "_bstate"}, 32'(best_state), 32'(e_bs));
        check_val({tag, "_bmetric"}, 32'(best_metric), 32'(e_bm));
        check_val({tag, "_norm"},  32'(norm_flag), 32'(e_norm));
        check_val({tag, "_cnt"},   32'(step_cnt), 32'(e_cnt));
    endtask

    function automatic logic [11:0] bms(input int b0, input int b1, input int b2, input int b3);
        return {3'(b3), 3'(b2), 3'(b1), 3'(b0)};
    endfunction

    task automatic do_step(input string tag, input logic fs, input logic [1:0] ss, input logic [11:0] bm);
        in_valid    = 1'b1;
        frame_start = fs;
        start_state = ss;
        bm_in       = bm;
        #1;
        check_val({tag, "_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        $display("step %s fs=%0d ss=%0d bm=%03h -> dec=%b best=%0d/%0d norm=%0d cnt=%0d",
                 tag, fs, ss, bm, dec_out, best_state, best_metric, norm_flag, step_cnt);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        start_state = '0;
        bm_in       = '0;
        dec_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check_val("rst_valid", 32'(dec_valid), 32'd0);
        check_val("rst_dec", 32'(dec_out), 32'd0);
        check_val("rst_bstate", 32'(best_state), 32'd0);
        check_val("rst_bmetric", 32'(best_metric), 32'd0);
        check_val("rst_norm", 32'(norm_flag), 32'd0);
        check_val("rst_cnt", 32'(step_cnt), 32'd0);
        check_val("rst_ready", 32'(in_ready), 32'd1);
        check_pm("rst", 0, 8, 8, 8);

        // Frame start from state 0, zero branch metrics
        do_step("fs0", 1'b1, 2'd0, bms(0, 0, 0, 0));
        check_out("fs0", 0, 0, 0, 0, 1);
        check_pm("fs0", 0, 0, 8, 8);

        // All metrics 7: growth, then normalisation on the third step only
        do_step("b7a", 1'b1, 2'd0, bms(7, 7, 7, 7));
        check_out("b7a", 0, 0, 7, 0, 1);
        check_pm("b7a", 7, 7, 15, 15);
        do_step("b7b", 1'b0, 2'd0, bms(7, 7, 7, 7));
        check_out("b7b", 0, 0, 14, 0, 2);
        check_pm("b7b", 14, 14, 14, 14);
        do_step("b7c", 1'b0, 2'd0, bms(7, 7, 7, 7));
        check_out("b7c", 0, 0, 5, 1, 3);
        check_pm("b7c", 5, 5, 5, 5);
        do_step("b7d", 1'b0, 2'd0, bms(7, 7, 7, 7));
        check_out("b7d", 0, 0, 12, 0, 4);

        // Non-zero start state: states 0 and 1 pick the p1 branch
        do_step("ss2", 1'b1, 2'd2, bms(0, 0, 0, 0));
        check_out("ss2", 4'b0011, 0, 0, 0, 1);
        check_pm("ss2", 0, 0, 8, 8);

        // Backpressure: consumer stalls for five cycles
        do_step("bp0", 1'b1, 2'd0, bms(0, 0, 0, 0));
        dec_ready   = 1'b0;
        in_valid    = 1'b1;
        frame_start = 1'b0;
        bm_in       = bms(7, 7, 7, 7);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check_val("bp_ready", 32'(in_ready), 32'd0);
            check_val("bp_valid", 32'(dec_valid), 32'd1);
            check_val("bp_cnt", 32'(step_cnt), 32'd1);
            check_val("bp_pm2", 32'(dut.pm_reg[2]), 32'd8);
            check_val("bp_bmetric", 32'(best_metric), 32'd0);
        end
        $display("stall 5 cycles cnt=%0d ready=%0d", step_cnt, in_ready);
        dec_ready = 1'b1;
        #1;
        check_val("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_out("bp_resume", 0, 0, 7, 0, 2);
        check_pm("bp_resume", 7, 7, 7, 7);

        // Noise-free encoded stream 1,0,1,1: received symbols 3,2,0,1
        do_step("enc1", 1'b1, 2'd0, bms(2, 1, 1, 0));
        check_out("enc1", 0, 1, 0, 0, 1);
        check_pm("enc1", 2, 0, 9, 9);
        do_step("enc2", 1'b0, 2'd0, bms(1, 2, 0, 1));
        check_out("enc2", 0, 2, 0, 0, 2);
        check_pm("enc2", 3, 3, 0, 2);
        do_step("enc3", 1'b0, 2'd0, bms(0, 1, 1, 2));
        check_out("enc3", 4'b1111, 1, 0, 0, 3);
        check_pm("enc3", 2, 0, 3, 3);
        do_step("enc4", 1'b0, 2'd0, bms(1, 0, 2, 1));
        check_out("enc4", 0, 3, 0, 0, 4);
        check_pm("enc4", 3, 3, 2, 0);

        // Mid-frame reset discards the pending word and reseeds metrics
        rst_n    = 1'b0;
        in_valid = 1'b1;
        bm_in    = bms(7, 7, 7, 7);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        check_val("mrst_valid", 32'(dec_valid), 32'd0);
        check_val("mrst_cnt", 32'(step_cnt), 32'd0);
        check_pm("mrst", 0, 8, 8, 8);
        $display("mid-frame reset valid=%0d cnt=%0d", dec_valid, step_cnt);
        do_step("post_rst", 1'b0, 2'd0, bms(0, 0, 0, 0));
        check_out("post_rst", 0, 0, 0, 0, 1);
        check_pm("post_rst", 0, 0, 8, 8);

        // Step counter wrap without frame_start
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        bm_in    = bms(0, 0, 0, 0);
        repeat (65535) @(posedge clk);
        #1;
        check_val("wrap_ffff", 32'(step_cnt), 32'h0000_ffff);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("wrap_zero", 32'(step_cnt), 32'd0);
        check_val("wrap_valid", 32'(dec_valid), 32'd1);
        $display("wrap run 65536 steps cnt=%0d", step_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
